// File: rtl/switch_debouncer.sv
// Slide-switch conditioner: 2-flop sync, shared prescaler tick, per-bit debounce lanes.
// Optional change-pulse outputs built when SWITCH_DEBOUNCER_CHANGE_PULSE_EN is defined.

module switch_debouncer_lane #(
  parameter int DEBOUNCE_TICKS = 10,
  parameter int CW             = $clog2(DEBOUNCE_TICKS + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic sync_in,
  output logic clean
);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;

  // Any agreement clears the count, so a bounce forces a full restart.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    if (sync_in == clean_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_q == CNT_LAST) begin
        clean_d = sync_in;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

  assign clean = clean_q;
endmodule

module switch_debouncer #(
  parameter int WIDTH          = 18,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_changed
);
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    sync1_d = sw_raw;
    sync2_d = sync1_q;
    presc_d = tick ? '0 : presc_q + PRESC_ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    switch_debouncer_lane #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .sync_in (sync2_q[g]),
      .clean   (sw_clean[g])
    );
  end

`ifdef SWITCH_DEBOUNCER_CHANGE_PULSE_EN
  logic [WIDTH-1:0] prev_q, prev_d, chg_q, chg_d;
  logic             any_q, any_d;

  always_comb begin
    prev_d = sw_clean;
    chg_d  = sw_clean ^ prev_q;
    any_d  = |(sw_clean ^ prev_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q <= '0;
      chg_q  <= '0;
      any_q  <= 1'b0;
    end else begin
      prev_q <= prev_d;
      chg_q  <= chg_d;
      any_q  <= any_d;
    end
  end

  assign sw_changed  = chg_q;
  assign any_changed = any_q;
`else
  assign sw_changed  = '0;
  assign any_changed = 1'b0;
`endif
endmodule
